// File: rtl/piso_pkg.sv
// Shared types and constants for the parametrised PISO serializer.
// The optional parity bit is enabled by defining PISO_SERIALIZER_PARITY_EN.
package piso_pkg;

    localparam int PISO_MIN_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

    // The counter needs to represent 0..DATA_W.
    function automatic int piso_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-word holding register for piso_serializer.
// Captures a word mid-frame and hands it, or a bypassed input word, to the shifter.
module piso_hold_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    input  logic              frame_done,
    output logic              ready,
    output logic              full,
    output logic              load,
    output logic [DATA_W-1:0] load_word
);

    logic [DATA_W-1:0] hold_q;
    logic              full_q;

    assign ready = !full_q;
    assign full  = full_q;

    // When the shifter is free, a held word wins; otherwise an accepted word bypasses.
    assign load      = frame_done && (full_q || valid);
    assign load_word = full_q ? hold_q : data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else if (frame_done && full_q) begin
            full_q <= 1'b0;
        end else if (valid && !full_q && !frame_done) begin
            hold_q <= data;
            full_q <= 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parametrised parallel-in/serial-out serializer with a one-word holding buffer.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
//
// Input handshake: a word transfers on a rising clock edge where inValid && inReady;
// inReady depends only on registered state, and parallelIn must hold while inValid is high.
module piso_serializer
    import piso_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  bit MSB_FIRST = 1'b0,
    localparam int CNT_W     = piso_cnt_w(DATA_W)
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic [DATA_W-1:0] parallelIn,
    input  logic              inValid,
    output logic              inReady,
    output logic              serialOut,
    output logic              bitValid,
    output logic              frameStart,
    output logic              frameEnd,
    output logic              busy,
    output piso_state_e       state_dbg
);

    generate
        if (DATA_W < PISO_MIN_W) begin : g_bad_width
            $error("piso_serializer: DATA_W must be at least %0d", PISO_MIN_W);
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
`ifndef PISO_SERIALIZER_PARITY_EN
    localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(DATA_W - 2);
`endif

    piso_state_e       state_q, state_n;
    logic [DATA_W-1:0] sh_q, sh_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              so_q, so_n, bv_q, bv_n, fs_q, fs_n, fe_q, fe_n;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic              par_q, par_n;
`endif
    logic              frame_done, load, hold_full;
    logic [DATA_W-1:0] load_word;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // The edge on which the shifter can take a new word without leaving a gap.
`ifdef PISO_SERIALIZER_PARITY_EN
    assign frame_done = (state_q == IDLE) || (state_q == PARITY);
`else
    assign frame_done = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST_IDX));
`endif

    piso_hold_buf #(.DATA_W(DATA_W)) u_hold (
        .clock      (clock),
        .reset_n    (resetN),
        .data       (parallelIn),
        .valid      (inValid),
        .frame_done (frame_done),
        .ready      (inReady),
        .full       (hold_full),
        .load       (load),
        .load_word  (load_word)
    );

    always_comb begin
        state_n = state_q;
        sh_n    = sh_q;
        cnt_n   = cnt_q;
        so_n    = 1'b0;
        bv_n    = 1'b0;
        fs_n    = 1'b0;
        fe_n    = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
        par_n   = par_q;
`endif
        if (load) begin
            // The first bit goes out on the load edge, so the shifter keeps only the rest.
            state_n = SHIFT;
            sh_n    = shift_out(load_word);
            cnt_n   = '0;
            so_n    = first_bit(load_word);
            bv_n    = 1'b1;
            fs_n    = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_n   = ^load_word;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q != LAST_IDX) begin
                        sh_n  = shift_out(sh_q);
                        so_n  = first_bit(sh_q);
                        cnt_n = cnt_q + 1'b1;
                        bv_n  = 1'b1;
`ifndef PISO_SERIALIZER_PARITY_EN
                        fe_n  = (cnt_q == PENULT_IDX);
`endif
                    end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
                        state_n = PARITY;
                        so_n    = par_q;
                        bv_n    = 1'b1;
                        fe_n    = 1'b1;
`else
                        state_n = IDLE;
                        cnt_n   = '0;
`endif
                    end
                end
`ifdef PISO_SERIALIZER_PARITY_EN
                PARITY: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            so_q    <= 1'b0;
            bv_q    <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            sh_q    <= sh_n;
            cnt_q   <= cnt_n;
            so_q    <= so_n;
            bv_q    <= bv_n;
            fs_q    <= fs_n;
            fe_q    <= fe_n;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    assign serialOut  = so_q;
    assign bitValid   = bv_q;
    assign frameStart = fs_q;
    assign frameEnd   = fe_q;
    assign busy       = (state_q != IDLE) || hold_full;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: an 8-bit LSB-first and a 12-bit MSB-first instance.
// Expected bit streams are hand-written in transmission order; parity bits are appended when enabled.
module tb_piso_serializer;
    import piso_pkg::*;

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clock = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    logic [7:0]  d8 = '0;
    logic [11:0] d12 = '0;
    logic        v8 = 1'b0, v12 = 1'b0;
    logic        r8, so8, bv8, fs8, fe8, busy8;
    logic        r12, so12, bv12, fs12, fe12, busy12;
    piso_state_e st8, st12;

    piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) dut8 (
        .clock(clock), .resetN(resetN), .parallelIn(d8), .inValid(v8), .inReady(r8),
        .serialOut(so8), .bitValid(bv8), .frameStart(fs8), .frameEnd(fe8),
        .busy(busy8), .state_dbg(st8)
    );

    piso_serializer #(.DATA_W(12), .MSB_FIRST(1'b1)) dut12 (
        .clock(clock), .resetN(resetN), .parallelIn(d12), .inValid(v12), .inReady(r12),
        .serialOut(so12), .bitValid(bv12), .frameStart(fs12), .frameEnd(fe12),
        .busy(busy12), .state_dbg(st12)
    );

    // Each entry is {serialOut, frameStart, frameEnd}.
    logic [2:0] exp8_q[$];
    logic [2:0] exp12_q[$];
    logic [2:0] e8, e12;
    int checks = 0;
    int errors = 0;
    int run8 = 0, last_run8 = 0, run12 = 0, last_run12 = 0, bits8 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // seq holds the frame's data bits in transmission order, first bit at seq[n-1].
    task automatic push_seq(input bit sel12, input logic [15:0] seq, input int n, input logic par);
        logic [2:0] ent;
        for (int i = 0; i < n; i++) begin
            ent = {seq[n-1-i], (i == 0), (EXTRA == 0) && (i == n - 1)};
            if (sel12) exp12_q.push_back(ent);
            else       exp8_q.push_back(ent);
        end
        if (EXTRA != 0) begin
            if (sel12) exp12_q.push_back({par, 1'b0, 1'b1});
            else       exp8_q.push_back({par, 1'b0, 1'b1});
        end
    endtask

    task automatic send(input bit sel12, input logic [11:0] w);
        bit acc = 1'b0;
        int k = 0;
        @(negedge clock);
        if (sel12) begin d12 = w; v12 = 1'b1; end
        else begin d8 = w[7:0]; v8 = 1'b1; end
        while (!acc && k < 200) begin
            acc = sel12 ? r12 : r8;
            @(posedge clock);
            if (!acc) @(negedge clock);
            k++;
        end
        #1;
        v8 = 1'b0;
        v12 = 1'b0;
        check(sel12 ? "accept12" : "accept8", acc, 1);
    endtask

    task automatic wait_idle(input bit sel12);
        bit done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clock);
            #1;
            if (sel12) done = !busy12 && !bv12;
            else       done = !busy8 && !bv8;
        end
        check(sel12 ? "idle12_timeout" : "idle8_timeout", done, 1);
    endtask

    always @(negedge clock) begin
        if (!resetN) begin
            run8 = 0;
            run12 = 0;
        end else begin
            if (bv8) begin
                bits8++;
                run8++;
                if (exp8_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut8_unexpected_bit: got so=%0b, expected no bit", so8);
                end else begin
                    e8 = exp8_q.pop_front();
                    check("dut8_bit{so,fs,fe}", {29'd0, so8, fs8, fe8}, {29'd0, e8});
                end
            end else if (run8 != 0) begin
                last_run8 = run8;
                run8 = 0;
            end
            if (bv12) begin
                run12++;
                if (exp12_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut12_unexpected_bit: got so=%0b, expected no bit", so12);
                end else begin
                    e12 = exp12_q.pop_front();
                    check("dut12_bit{so,fs,fe}", {29'd0, so12, fs12, fe12}, {29'd0, e12});
                end
            end else if (run12 != 0) begin
                last_run12 = run12;
                run12 = 0;
            end
        end
    end

    initial begin
        int base;
        bit seen;

        #12;
        check("reset_out8", {so8, bv8, fs8, fe8, busy8}, 5'b0);
        check("reset_ready8", r8, 1);
        check("reset_state8", st8, IDLE);
        check("reset_out12", {so12, bv12, fs12, fe12, busy12}, 5'b0);
        check("reset_ready12", r12, 1);
        @(negedge clock);
        resetN = 1'b1;

        // Single frame 8'hA5, LSB first.
        push_seq(1'b0, 16'b10100101, 8, 1'b0);
        send(1'b0, 12'h0A5);
        wait_idle(1'b0);
        check("a5_run_len", last_run8, 8 + EXTRA);
        check("a5_bitvalid_after", bv8, 0);

        // Back-to-back 01, 80, FF with inValid kept asserted.
        push_seq(1'b0, 16'b10000000, 8, 1'b1);
        push_seq(1'b0, 16'b00000001, 8, 1'b1);
        push_seq(1'b0, 16'b11111111, 8, 1'b0);
        send(1'b0, 12'h001);
        send(1'b0, 12'h080);
        @(negedge clock);
        check("b2b_ready_low_hold_full", r8, 0);
        check("b2b_busy", busy8, 1);
        send(1'b0, 12'h0FF);
        check("b2b_ready_low_again", r8, 0);
        wait_idle(1'b0);
        check("b2b_run_len", last_run8, 3 * (8 + EXTRA));
        check("b2b_ready_after_drain", r8, 1);

        // Bypass: next word offered during the frameEnd cycle with the holding buffer empty.
        push_seq(1'b0, 16'b10100101, 8, 1'b0);
        push_seq(1'b0, 16'b10000000, 8, 1'b1);
        send(1'b0, 12'h0A5);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clock);
            #1;
            seen = fe8;
        end
        check("bypass_saw_frame_end", seen, 1);
        send(1'b0, 12'h001);
        wait_idle(1'b0);
        check("bypass_run_len", last_run8, 2 * (8 + EXTRA));

        // 8'h07 twice back-to-back.
        push_seq(1'b0, 16'b11100000, 8, 1'b1);
        push_seq(1'b0, 16'b11100000, 8, 1'b1);
        send(1'b0, 12'h007);
        send(1'b0, 12'h007);
        wait_idle(1'b0);
        check("x07_run_len", last_run8, 2 * (8 + EXTRA));

        // 12-bit MSB first: C03 alone, then C03 and ABC back-to-back.
        push_seq(1'b1, 16'b110000000011, 12, 1'b0);
        send(1'b1, 12'hC03);
        wait_idle(1'b1);
        check("c03_run_len", last_run12, 12 + EXTRA);
        push_seq(1'b1, 16'b110000000011, 12, 1'b0);
        push_seq(1'b1, 16'b101010111100, 12, 1'b1);
        send(1'b1, 12'hC03);
        send(1'b1, 12'hABC);
        wait_idle(1'b1);
        check("w12_b2b_run_len", last_run12, 2 * (12 + EXTRA));

        // Reset mid-frame with a word held: F0 aborted after 3 bits, 55 never emitted.
        push_seq(1'b0, 16'b00001111, 8, 1'b0);
        base = bits8;
        send(1'b0, 12'h0F0);
        send(1'b0, 12'h055);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            #1;
            seen = (bits8 >= base + 3);
        end
        check("midreset_three_bits", seen, 1);
        check("midreset_hold_full", r8, 0);
        resetN = 1'b0;
        exp8_q.delete();
        #1;
        check("midreset_outputs", {so8, bv8, fs8, fe8, busy8}, 5'b0);
        check("midreset_ready", r8, 1);
        check("midreset_state", st8, IDLE);
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("midreset_quiet_after_release", {bv8, busy8}, 2'b0);
        push_seq(1'b0, 16'b00111100, 8, 1'b0);
        send(1'b0, 12'h03C);
        wait_idle(1'b0);
        repeat (12) @(negedge clock);
        check("midreset_run_len", last_run8, 8 + EXTRA);
        check("exp8_drained", exp8_q.size(), 0);
        check("exp12_drained", exp12_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
